// File: rtl/sram_1r1w_fifo_ctrl.sv
// Streaming valid/ready FIFO built around a 1-write/1-read SRAM macro, with a
// 2-entry output skid buffer that absorbs the one-cycle macro read latency.
module sram_1r1w_fifo_ctrl #(
    parameter int DATA_WIDTH = 576,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   sram_cnt_r;
    logic                  inflight_r;
    logic [1:0]            skid_cnt_r;
    logic [DATA_WIDTH-1:0] skid0_r;
    logic [DATA_WIDTH-1:0] skid1_r;

    logic                  push_s;
    logic                  pop_s;
    logic                  issue_s;
    logic [2:0]            pending_s;

    // Handshake decode and macro port drive from registered occupancy
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = (skid_cnt_r != 2'd0);
        pop_s      = 1'b0;
        push_s     = 1'b0;
        issue_s    = 1'b0;
        pending_s  = {1'b0, skid_cnt_r} + {2'b00, inflight_r};
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            in_ready = (sram_cnt_r < DEPTH_C);
        end
        push_s = in_valid && in_ready;
        pop_s  = out_valid && out_ready;
        // Skid slots already promised minus the one leaving this edge must leave room
        if ((sram_cnt_r != {(ADDR_WIDTH+1){1'b0}}) && (pending_s < (3'd2 + {2'b00, pop_s}))) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
        sram_csb0  = ~push_s;
        sram_addr0 = wr_ptr_r;
        sram_din0  = in_data;
        sram_csb1  = ~issue_s;
        sram_addr1 = rd_ptr_r;
        out_data   = skid0_r;
        level      = sram_cnt_r + {{ADDR_WIDTH{1'b0}}, inflight_r}
                   + {{(ADDR_WIDTH-1){1'b0}}, skid_cnt_r};
    end

    // SRAM pointers, occupancy and skid bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
            rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
            sram_cnt_r <= {(ADDR_WIDTH+1){1'b0}};
            inflight_r <= 1'b0;
            skid_cnt_r <= 2'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, issue_s})
                2'b10:   sram_cnt_r <= sram_cnt_r + CNT_ONE;
                2'b01:   sram_cnt_r <= sram_cnt_r - CNT_ONE;
                default: sram_cnt_r <= sram_cnt_r;
            endcase
            inflight_r <= issue_s;
            case ({inflight_r, pop_s})
                2'b10:   skid_cnt_r <= skid_cnt_r + 2'd1;
                2'b01:   skid_cnt_r <= skid_cnt_r - 2'd1;
                default: skid_cnt_r <= skid_cnt_r;
            endcase
        end
    end

    // Skid payload; macro read data is captured only on the edge after an issue
    always_ff @(posedge clk) begin
        case ({inflight_r, pop_s})
            2'b10: begin
                if (skid_cnt_r == 2'd0) begin
                    skid0_r <= sram_dout1;
                end else begin
                    skid1_r <= sram_dout1;
                end
            end
            2'b01: begin
                skid0_r <= skid1_r;
            end
            2'b11: begin
                if (skid_cnt_r == 2'd1) begin
                    skid0_r <= sram_dout1;
                end else begin
                    skid0_r <= skid1_r;
                    skid1_r <= sram_dout1;
                end
            end
            default: begin
                skid0_r <= skid0_r;
                skid1_r <= skid1_r;
            end
        endcase
    end
endmodule

// Protocol checker: the macro must never see a same-address write and read.
module sram_1r1w_fifo_ctrl_chk #(
    parameter int ADDR_WIDTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  sram_csb0,
    input logic                  sram_csb1,
    input logic [ADDR_WIDTH-1:0] sram_addr0,
    input logic [ADDR_WIDTH-1:0] sram_addr1,
    input logic [ADDR_WIDTH:0]   level
);
    localparam logic [ADDR_WIDTH:0] LEVEL_MAX = {1'b1, {(ADDR_WIDTH-2){1'b0}}, 2'b10};

    a_no_collision: assert property (@(posedge clk) disable iff (rst)
        !(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)))
        else $error("collision on address %0d", sram_addr0);

    a_level_bound: assert property (@(posedge clk) disable iff (rst) level <= LEVEL_MAX)
        else $error("level %0d out of range", level);
endmodule

// File: tb/tb_sram_1r1w_fifo_ctrl.sv
// Directed bench for sram_1r1w_fifo_ctrl with a behavioural 0rw1r1w macro model
// and a scoreboard of accepted words checked at every pop.
module tb_sram_1r1w_fifo_ctrl;
    localparam int DW    = 576;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] JUNK = {18{32'hDEADBEEF}};

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          sram_csb0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic          sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] q[$];

    sram_1r1w_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level),
        .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    sram_1r1w_fifo_ctrl_chk #(.ADDR_WIDTH(AW)) chk (
        .clk(clk), .rst(rst), .sram_csb0(sram_csb0), .sram_csb1(sram_csb1),
        .sram_addr0(sram_addr0), .sram_addr1(sram_addr1), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: sample at posedge, write/read at negedge, data garbage after hold
    logic [DW-1:0] mem [DEPTH];
    logic          wr_pend;
    logic          rd_pend;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra;
    logic [DW-1:0] wd;

    always @(posedge clk) begin
        wr_pend <= !sram_csb0;
        wa      <= sram_addr0;
        wd      <= sram_din0;
        rd_pend <= !sram_csb1;
        ra      <= sram_addr1;
    end

    always @(negedge clk) begin
        if (wr_pend) mem[wa] <= wd;
        if (rd_pend) sram_dout1 <= mem[ra];
    end

    always begin
        @(posedge clk);
        #1;
        sram_dout1 <= JUNK;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) q.push_back(in_data);
            if (out_valid && out_ready) begin
                check("pop_q_nonempty", DW'(q.size() != 0), DW'(1));
                if (q.size() != 0) check("pop_data", out_data, q.pop_front());
            end
            check("level_max", DW'(level > 5'd18), DW'(0));
        end
    end

    task automatic drain(input int bound);
        int c = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((out_valid || level != 5'd0) && c < bound) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_level", DW'(level), DW'(0));
        check("drain_q_empty", DW'(q.size()), DW'(0));
        out_ready = 1'b0;
    endtask

    initial begin
        int pushed;
        int guard;
        rst = 1'b1; in_valid = 1'b1; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_level", DW'(level), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(0));
        check("rst_csb0", DW'(sram_csb0), DW'(1));
        check("rst_csb1", DW'(sram_csb1), DW'(1));
        in_valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;

        // 1: single word latency
        in_valid = 1'b1; in_data = DW'(1); out_ready = 1'b1; #1;
        check("t1_csb0", DW'(sram_csb0), DW'(0));
        check("t1_addr0", DW'(sram_addr0), DW'(0));
        @(posedge clk); #1;
        in_valid = 1'b0; #1;
        check("t1_csb1", DW'(sram_csb1), DW'(0));
        check("t1_addr1", DW'(sram_addr1), DW'(0));
        check("t1_level_k", DW'(level), DW'(1));
        @(posedge clk); #1;
        check("t1_valid_k1", DW'(out_valid), DW'(0));
        check("t1_level_k1", DW'(level), DW'(1));
        @(posedge clk); #1;
        check("t1_valid_k2", DW'(out_valid), DW'(1));
        check("t1_data_k2", out_data, DW'(1));
        @(posedge clk); #1;
        check("t1_valid_pop", DW'(out_valid), DW'(0));
        check("t1_level_pop", DW'(level), DW'(0));

        // 2: fill to DEPTH+2, then drain in order at full rate
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            in_valid = 1'b1; in_data = DW'(i); #1;
            check("t2_in_ready", DW'(in_ready), DW'(1));
            @(posedge clk); #1;
        end
        in_data = DW'(99); #1;
        check("t2_full_in_ready", DW'(in_ready), DW'(0));
        check("t2_full_csb0", DW'(sram_csb0), DW'(1));
        check("t2_full_level", DW'(level), DW'(18));
        check("t2_head", out_data, DW'(0));
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("t2_hold_level", DW'(level), DW'(18));
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            check("t2_drain_valid", DW'(out_valid), DW'(1));
            check("t2_drain_data", out_data, DW'(i));
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        check("t2_empty_level", DW'(level), DW'(0));
        check("t2_empty_valid", DW'(out_valid), DW'(0));

        // 3: continuous streaming
        out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            in_valid = 1'b1; in_data = DW'(1000 + c); #1;
            check("t3_in_ready", DW'(in_ready), DW'(1));
            if (c >= 3) check("t3_out_valid", DW'(out_valid), DW'(1));
            @(posedge clk); #1;
        end
        drain(50);

        // 4: random stalls across several pointer wraps
        pushed = 0;
        for (int c = 0; c < 3000 && pushed < 50; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = DW'(2000 + pushed);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) pushed++;
            @(posedge clk); #1;
        end
        check("t4_pushed", DW'(pushed), DW'(50));
        drain(200);

        // 5: full with a single pop frees exactly one slot
        out_ready = 1'b0; in_valid = 1'b1; guard = 0;
        while (level != 5'd18 && guard < 40) begin
            in_data = DW'(3000 + guard);
            @(posedge clk); #1;
            guard++;
        end
        check("t5_full_level", DW'(level), DW'(18));
        check("t5_full_in_ready", DW'(in_ready), DW'(0));
        in_data = DW'(3100); out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t5_in_ready_rise", DW'(in_ready), DW'(1));
        check("t5_level_17", DW'(level), DW'(17));
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t5_level_refull", DW'(level), DW'(18));
        check("t5_in_ready_fall", DW'(in_ready), DW'(0));
        drain(100);

        // 6: asynchronous reset with a read in flight
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(4000 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("t6_level_7", DW'(level), DW'(7));
        in_valid = 1'b1; in_data = DW'(5555); #1;
        rst = 1'b1; #1;
        check("t6_rst_valid", DW'(out_valid), DW'(0));
        check("t6_rst_level", DW'(level), DW'(0));
        check("t6_rst_csb0", DW'(sram_csb0), DW'(1));
        check("t6_rst_csb1", DW'(sram_csb1), DW'(1));
        q.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = DW'(10);
        @(posedge clk); #1;
        in_valid = 1'b0; guard = 0;
        while (!out_valid && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check("t6_first_valid", DW'(out_valid), DW'(1));
        check("t6_first_data", out_data, DW'(10));
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
